// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and helpers for the load/store unit: access
//               size encoding, FSM state encoding and byte-strobe decode.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Access size as presented on req_size
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_t;

    // Unit sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Width of the read-latency down-counter (holds READ_LATENCY+1, max 4)
    localparam int unsigned CNT_BITS = 3;

    // Byte-lane write strobes for a store of the given size; the addressed
    // byte always sits on lane 0, so the mask grows upward from bit 0.
    function automatic logic [3:0] strobe_for(input lsu_size_t size);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001;
            SZ_HALF: mask = 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Request/response handshake from the execute stage plus the
//               byte-lane data-memory port, bundled for the load/store unit.
//               slave  = the load/store unit itself
//               master = its environment (execute stage and data memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;

    // Execute-stage request
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // Response back to the execute stage
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;

    // Data-memory port
    logic [31:0] mem_read_addr;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_write_enable;
    logic [31:0] mem_data_out;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_data_out,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output mem_read_addr, mem_write_addr, mem_data_in, mem_write_enable
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_data_out,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  mem_read_addr, mem_write_addr, mem_data_in, mem_write_enable
    );

endinterface
`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_extend
// Description : Combinational load-data formatter. Byte loads take lane 0,
//               half loads lanes 1:0; both are sign- or zero-extended.
//               Word loads pass straight through.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] raw_i,
    input  lsu_size_t   size_i,
    input  logic        unsigned_i,
    output logic [31:0] result_o
);

    // Select the addressed lanes and widen them to a full word
    always_comb begin
        result_o = raw_i;
        case (size_i)
            SZ_BYTE: result_o = {{24{raw_i[7]  & ~unsigned_i}}, raw_i[7:0]};
            SZ_HALF: result_o = {{16{raw_i[15] & ~unsigned_i}}, raw_i[15:0]};
            default: result_o = raw_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit in front of a 32-bit
//               byte-lane data memory. Checks size/alignment/range at
//               accept, drives the memory port, waits out the read latency
//               and returns extended load data with a one-cycle response.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,   // 1..3
    parameter int unsigned ADDR_BITS    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);

    // Counter preload: the READ state lasts READ_LATENCY+1 cycles because
    // the address itself is registered one cycle before the memory sees it.
    localparam logic [CNT_BITS-1:0] c_cnt_load = CNT_BITS'(READ_LATENCY + 1);

    lsu_state_t          state_q, state_d;
    lsu_size_t           size_q, size_d;
    logic                uns_q, uns_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic [31:0]         mem_read_addr_q, mem_read_addr_d;
    logic [31:0]         mem_write_addr_q, mem_write_addr_d;
    logic [31:0]         mem_data_in_q, mem_data_in_d;
    logic [3:0]          mem_we_q, mem_we_d;

    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [31:0]         resp_rdata_q, resp_rdata_d;

    lsu_size_t           w_req_size;
    logic                w_req_ready;
    logic                w_req_err;
    logic [31:0]         w_ext_data;

    assign w_req_size  = lsu_size_t'(bus.req_size);
    assign w_req_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);

    // Reject illegal size, misalignment and addresses beyond the implemented range
    always_comb begin
        w_req_err = 1'b0;
        case (w_req_size)
            SZ_ILL:  w_req_err = 1'b1;
            SZ_HALF: w_req_err = bus.req_addr[0];
            SZ_WORD: w_req_err = (bus.req_addr[1:0] != 2'b00);
            default: w_req_err = 1'b0;
        endcase
        if ((bus.req_addr >> ADDR_BITS) != 32'd0) begin
            w_req_err = 1'b1;
        end
    end

    lsu_load_extend u_load_extend (
        .raw_i      (bus.mem_data_out),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (w_ext_data)
    );

    // Next-state and next-output decode; strobes and response default to off
    always_comb begin
        state_d          = state_q;
        size_d           = size_q;
        uns_d            = uns_q;
        cnt_d            = cnt_q;
        mem_read_addr_d  = mem_read_addr_q;
        mem_write_addr_d = mem_write_addr_q;
        mem_data_in_d    = mem_data_in_q;
        mem_we_d         = 4'b0000;
        resp_valid_d     = 1'b0;
        resp_err_d       = 1'b0;
        resp_rdata_d     = 32'd0;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (bus.req_valid) begin
                    size_d = w_req_size;
                    uns_d  = bus.req_unsigned;
                    if (w_req_err) begin
                        // No memory access for a faulting request
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (bus.req_we) begin
                        // Store data goes out unshifted: byte at A is lane 0
                        state_d          = ST_WRITE;
                        mem_write_addr_d = bus.req_addr;
                        mem_data_in_d    = bus.req_wdata;
                        mem_we_d         = strobe_for(w_req_size);
                    end else begin
                        state_d         = ST_READ;
                        mem_read_addr_d = bus.req_addr;
                        cnt_d           = c_cnt_load;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end

            ST_READ: begin
                if (cnt_q == CNT_BITS'(1)) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = w_ext_data;
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset drops strobes immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            size_q           <= SZ_BYTE;
            uns_q            <= 1'b0;
            cnt_q            <= '0;
            mem_read_addr_q  <= 32'd0;
            mem_write_addr_q <= 32'd0;
            mem_data_in_q    <= 32'd0;
            mem_we_q         <= 4'b0000;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= 32'd0;
        end else begin
            state_q          <= state_d;
            size_q           <= size_d;
            uns_q            <= uns_d;
            cnt_q            <= cnt_d;
            mem_read_addr_q  <= mem_read_addr_d;
            mem_write_addr_q <= mem_write_addr_d;
            mem_data_in_q    <= mem_data_in_d;
            mem_we_q         <= mem_we_d;
            resp_valid_q     <= resp_valid_d;
            resp_err_q       <= resp_err_d;
            resp_rdata_q     <= resp_rdata_d;
        end
    end

    assign bus.req_ready        = w_req_ready;
    assign bus.resp_valid       = resp_valid_q;
    assign bus.resp_err         = resp_err_q;
    assign bus.resp_rdata       = resp_rdata_q;
    assign bus.mem_read_addr    = mem_read_addr_q;
    assign bus.mem_write_addr   = mem_write_addr_q;
    assign bus.mem_data_in      = mem_data_in_q;
    assign bus.mem_write_enable = mem_we_q;

endmodule
`default_nettype wire
